ahb_arb_ctrl: RTL and testbench
===============================

Name: ahb_arb_ctrl

Overview:
Sequential AHB bus arbiter controller for up to 16 masters. It owns grant sequencing: round-robin selection among requesters, burst-boundary handover, locked-transfer hold, and per-master SPLIT masking and unmasking. It drives hgrantx, hmaster and hmastlock to the address/data muxes and the slaves, replacing the ad-hoc combinational grant logic.

Parameters:
NUM_MST, 16, number of masters (2..16); request and grant vectors are 16 bits wide, and bits at or above NUM_MST are ignored.
DEFAULT_MST, 0, master granted when nobody requests; also the reset owner.

Ports:
hclk  input  1  bus clock
hrst_n  input  1  reset, synchronous, active-low
hbusreqx  input  16  per-master bus request
hlockx  input  16  per-master locked-transfer request
hsplitx  input  16  per-master split-resume from slaves (one-cycle pulses)
htrans  input  2  current transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hready  input  1  transfer-complete from the selected slave
hresp  input  2  slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
hgrantx  output  16  one-hot grant, registered
hmaster  output  4  index of the master owning the address phase
hmastlock  output  1  current address phase is locked
split_mask  output  16  masters currently parked by SPLIT
lock_split_err  output  1  one-cycle pulse: a locked master received SPLIT

Behaviour:
- Reset: all flops are cleared by a synchronous reset on the hclk edge while hrst_n=0. Reset values:
  - hgrantx = 1<<DEFAULT_MST
  - hmaster = DEFAULT_MST
  - hmastlock = 0
  - split_mask = 0
  - lock_split_err = 0
  - rr_ptr = DEFAULT_MST
  - state = IDLE
- Eligible vector: elig = hbusreqx & ~split_mask & valid_mask(NUM_MST).
- Arbitration point (AP): hready=1 and htrans is IDLE or NONSEQ. No handover occurs during BUSY or SEQ, so bursts are never broken.
- Round-robin selection: search elig starting at rr_ptr+1 and wrap at NUM_MST-1 to 0. The first set bit wins. rr_ptr takes the winner index whenever a new winner is granted.
- States:
  - IDLE: no eligible requester; the grant sits on DEFAULT_MST. At an AP with elig!=0, go to OWN and grant the winner.
  - OWN: a master holds the grant, unlocked.
    - At an AP, if hlockx[owner]=1 and hbusreqx[owner]=1: go to LOCK and keep the grant.
    - Otherwise at an AP, re-arbitrate: if elig!=0, grant the winner (may be the same master) and stay in OWN; if elig=0, go to IDLE.
  - LOCK: the grant is frozen and hbusreqx changes are ignored. Exit at an AP where hlockx[owner]=0, re-arbitrating as in OWN.
- Grant latency: hgrantx updates on the clock edge that samples the AP, so it is visible one cycle after the AP.
- Ownership handover: hmaster and hmastlock update on every edge with hready=1. Values loaded:
  - hmaster <= index(hgrantx)
  - hmastlock <= (state==LOCK) or (hlockx[granted] at that edge)
  - When hready=0, both hold.
- SPLIT masking: sampled hready=1 with hresp=SPLIT sets split_mask[hmaster].
  - The grant is forced off that master on the same edge: re-arbitrate excluding it, or fall back to DEFAULT_MST.
  - If state==LOCK, pulse lock_split_err and exit to OWN/IDLE.
- SPLIT unmasking: hsplitx[i]=1 clears split_mask[i] on the next edge. If the same edge also sets the same bit, the set wins.
- RETRY: no mask change. In LOCK the grant is held; in OWN it is treated as a normal AP.
- ERROR: no effect on arbitration.
- Default master masked: if DEFAULT_MST is in split_mask and elig=0, hgrantx=0 (dummy master) and hmaster holds its last value.
- hresp with hready=0 (first cycle of a two-cycle response) is ignored.
- Reset asserted mid-transfer or mid-lock: everything returns to the reset values on that edge.

Test Plan:
1. Round-robin: hbusreqx=0x000F held, bursts of single NONSEQ transfers with hready=1 -> hgrantx sequence 0x0002, 0x0004, 0x0008, 0x0001 and repeating; hmaster follows one hready-edge later.
2. Burst protection: master 1 is granted and issues NONSEQ+3×SEQ while master 2 requests -> hgrantx stays 0x0002 until the cycle after the last SEQ completes, then becomes 0x0004.
3. Lock: master 3 is granted with hlockx[3]=1 and masters 0 and 5 request -> grant held at 0x0008 and hmastlock=1 until hlockx[3]=0 at an AP, then grant goes to master 5.
4. SPLIT: hmaster=2 and hresp=11 across two cycles (hready 0 then 1) -> split_mask=0x0004 and grant moves off master 2; hsplitx=0x0004 pulse -> mask 0 next edge and master 2 is eligible again.
5. Idle/default: hbusreqx=0 -> hgrantx=0x0001 (DEFAULT_MST=0); with split_mask[0]=1 -> hgrantx=0x0000.
6. Reset: hrst_n=0 for one cycle while in LOCK with split_mask=0x0010 -> next cycle hgrantx=0x0001, hmaster=0, hmastlock=0, split_mask=0, state IDLE.

Source files
------------

// File: rtl/ahb_arb_ctrl.sv
// AHB bus arbiter controller: round-robin grant sequencing with burst protection,
// locked-transfer hold and per-master SPLIT masking for up to 16 masters.
module ahb_arb_ctrl #(
  parameter int unsigned NUM_MST     = 16,
  parameter int unsigned DEFAULT_MST = 0
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic [15:0] hbusreqx,
  input  logic [15:0] hlockx,
  input  logic [15:0] hsplitx,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic [15:0] hgrantx,
  output logic [3:0]  hmaster,
  output logic        hmastlock,
  output logic [15:0] split_mask,
  output logic        lock_split_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_LOCK
  } state_t;

  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [1:0]  RESP_SPLIT = 2'b11;
  localparam logic [15:0] VALID_MASK = 16'((33'h1 << NUM_MST) - 33'h1);
  localparam logic [15:0] DEF_OH     = 16'(16'h1 << DEFAULT_MST);
  localparam logic [3:0]  DEF_IDX    = 4'(DEFAULT_MST);

  state_t      state, state_n;
  logic [3:0]  rr_ptr, rr_n;
  logic [15:0] grant_n;
  logic [15:0] mask_n;
  logic [15:0] split_set;
  logic [15:0] elig_arb;
  logic [15:0] default_grant;
  logic [15:0] win_oh;
  logic [3:0]  win_idx;
  logic [3:0]  owner;
  logic        owner_valid;
  logic        ap;
  logic        split_now;
  logic        do_arb;
  logic        lse_n;

  assign ap        = hready && (htrans == TR_IDLE || htrans == TR_NONSEQ);
  assign split_now = hready && (hresp == RESP_SPLIT);
  assign split_set = split_now ? (16'h1 << hmaster) : '0;
  // A SPLIT landing on the same edge as its resume pulse keeps the master parked.
  assign mask_n    = ((split_mask & ~hsplitx) | split_set) & VALID_MASK;
  assign elig_arb  = hbusreqx & ~split_mask & ~split_set & VALID_MASK;
  assign default_grant = mask_n[DEFAULT_MST] ? '0 : DEF_OH;

  always_comb begin
    owner       = '0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (hgrantx[i]) begin
        owner       = 4'(i);
        owner_valid = 1'b1;
      end
    end
  end

  always_comb begin
    win_idx = rr_ptr;
    win_oh  = '0;
    for (int unsigned k = NUM_MST; k >= 1; k--) begin
      if (elig_arb[(32'(rr_ptr) + k) % NUM_MST]) begin
        win_idx = 4'((32'(rr_ptr) + k) % NUM_MST);
      end
    end
    if (elig_arb != '0) win_oh = 16'h1 << win_idx;
  end

  always_ff @(posedge hclk) begin
    if (!hrst_n) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    do_arb  = 1'b0;
    state_n = state;
    unique case (state)
      ST_IDLE: do_arb = ap || split_now;
      ST_OWN: begin
        if (split_now) do_arb = 1'b1;
        else if (ap && hlockx[owner] && hbusreqx[owner]) state_n = ST_LOCK;
        else if (ap) do_arb = 1'b1;
      end
      ST_LOCK: do_arb = split_now || (ap && !hlockx[owner]);
      default: do_arb = 1'b1;
    endcase
    if (do_arb) state_n = (elig_arb != '0) ? ST_OWN : ST_IDLE;
  end

  always_comb begin
    grant_n = hgrantx;
    rr_n    = rr_ptr;
    lse_n   = split_now && (state == ST_LOCK);
    if (do_arb && elig_arb != '0) begin
      grant_n = win_oh;
      rr_n    = win_idx;
    end else if (do_arb || state == ST_IDLE) begin
      grant_n = default_grant;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      hgrantx        <= DEF_OH;
      hmaster        <= DEF_IDX;
      hmastlock      <= 1'b0;
      split_mask     <= '0;
      lock_split_err <= 1'b0;
      rr_ptr         <= DEF_IDX;
    end else begin
      hgrantx        <= grant_n;
      split_mask     <= mask_n;
      lock_split_err <= lse_n;
      rr_ptr         <= rr_n;
      if (hready) begin
        if (owner_valid) hmaster <= owner;
        hmastlock <= owner_valid && ((state == ST_LOCK) || hlockx[owner]);
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb_ctrl.sv
// Directed bench for ahb_arb_ctrl: round-robin, burst hold, lock, SPLIT, default and reset.
module tb_ahb_arb_ctrl;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic [15:0] hbusreqx;
  logic [15:0] hlockx;
  logic [15:0] hsplitx;
  logic [1:0]  htrans;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hgrantx;
  logic [3:0]  hmaster;
  logic        hmastlock;
  logic [15:0] split_mask;
  logic        lock_split_err;

  int checks = 0;
  int failures = 0;

  ahb_arb_ctrl #(.NUM_MST(16), .DEFAULT_MST(0)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .hbusreqx(hbusreqx), .hlockx(hlockx),
    .hsplitx(hsplitx), .htrans(htrans), .hready(hready), .hresp(hresp),
    .hgrantx(hgrantx), .hmaster(hmaster), .hmastlock(hmastlock),
    .split_mask(split_mask), .lock_split_err(lock_split_err)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [15:0] req, input logic [15:0] lck, input logic [15:0] spl,
                       input logic [1:0] tr, input logic rdy, input logic [1:0] rsp);
    hbusreqx = req; hlockx = lck; hsplitx = spl; htrans = tr; hready = rdy; hresp = rsp;
  endtask

  task automatic do_reset();
    drive(16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 2'b00);
    hrst_n = 1'b0;
    step();
    hrst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hgrantx !== 16'h0001) begin failures++; $display("FAIL reset_grant got=%h exp=%h", hgrantx, 16'h0001); end
    checks++;
    if (hmaster !== 4'd0) begin failures++; $display("FAIL reset_hmaster got=%0d exp=0", hmaster); end
    checks++;
    if (hmastlock !== 1'b0 || lock_split_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags got lock=%b err=%b exp 0 0", hmastlock, lock_split_err);
    end
    checks++;
    if (split_mask !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0000", split_mask); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_g [5] = '{16'h0002, 16'h0004, 16'h0008, 16'h0001, 16'h0002};
    logic [3:0]  exp_m [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    do_reset();
    drive(16'h000F, 16'h0, 16'h0, 2'b10, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (hgrantx !== exp_g[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%h exp=%h", i, hgrantx, exp_g[i]); end
      checks++;
      if (hmaster !== exp_m[i]) begin failures++; $display("FAIL rr_hmaster[%0d] got=%0d exp=%0d", i, hmaster, exp_m[i]); end
    end
  endtask

  task automatic test_burst();
    logic [1:0]  tr  [5] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b00};
    logic        rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] eg  [5] = '{16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0004};
    do_reset();
    drive(16'h0002, 16'h0, 16'h0, 2'b00, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0002) begin failures++; $display("FAIL burst_first_grant got=%h exp=0002", hgrantx); end
    drive(16'h0002, 16'h0, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (hmaster !== 4'd1) begin failures++; $display("FAIL burst_hmaster got=%0d exp=1", hmaster); end
    for (int i = 0; i < 5; i++) begin
      drive(16'h0006, 16'h0, 16'h0, tr[i], rdy[i], 2'b00);
      step();
      checks++;
      if (hgrantx !== eg[i]) begin failures++; $display("FAIL burst_grant[%0d] got=%h exp=%h", i, hgrantx, eg[i]); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(16'h0008, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    step();
    checks++;
    if (hgrantx !== 16'h0008 || hmastlock !== 1'b1 || hmaster !== 4'd3) begin
      failures++; $display("FAIL lock_enter got g=%h l=%b m=%0d exp g=0008 l=1 m=3", hgrantx, hmastlock, hmaster);
    end
    drive(16'h0029, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    drive(16'h0021, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0008 || hmastlock !== 1'b1) begin
      failures++; $display("FAIL lock_hold got g=%h l=%b exp g=0008 l=1", hgrantx, hmastlock);
    end
    drive(16'h0021, 16'h0000, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0020) begin failures++; $display("FAIL lock_release_grant got=%h exp=0020", hgrantx); end
    step();
    checks++;
    if (hmaster !== 4'd5 || hmastlock !== 1'b0) begin
      failures++; $display("FAIL lock_after got m=%0d l=%b exp m=5 l=0", hmaster, hmastlock);
    end
  endtask

  task automatic test_split();
    do_reset();
    drive(16'h0004, 16'h0, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    drive(16'h0006, 16'h0, 16'h0, 2'b11, 1'b1, 2'b00);
    step();
    checks++;
    if (hmaster !== 4'd2 || hgrantx !== 16'h0004) begin
      failures++; $display("FAIL split_setup got m=%0d g=%h exp m=2 g=0004", hmaster, hgrantx);
    end
    drive(16'h0006, 16'h0, 16'h0, 2'b11, 1'b0, 2'b11);
    step();
    checks++;
    if (split_mask !== 16'h0 || hgrantx !== 16'h0004) begin
      failures++; $display("FAIL split_wait_ignored got mask=%h g=%h exp mask=0000 g=0004", split_mask, hgrantx);
    end
    drive(16'h0006, 16'h0, 16'h0004, 2'b00, 1'b1, 2'b11);
    step();
    checks++;
    if (split_mask !== 16'h0004 || hgrantx !== 16'h0002) begin
      failures++; $display("FAIL split_set got mask=%h g=%h exp mask=0004 g=0002", split_mask, hgrantx);
    end
    drive(16'h0006, 16'h0, 16'h0004, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (split_mask !== 16'h0 || hgrantx !== 16'h0002) begin
      failures++; $display("FAIL split_clear got mask=%h g=%h exp mask=0000 g=0002", split_mask, hgrantx);
    end
    drive(16'h0004, 16'h0, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0004) begin failures++; $display("FAIL split_regrant got=%h exp=0004", hgrantx); end
  endtask

  task automatic test_default();
    do_reset();
    step();
    checks++;
    if (hgrantx !== 16'h0001) begin failures++; $display("FAIL default_grant got=%h exp=0001", hgrantx); end
    drive(16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 2'b11);
    step();
    checks++;
    if (split_mask !== 16'h0001 || hgrantx !== 16'h0000) begin
      failures++; $display("FAIL default_masked got mask=%h g=%h exp mask=0001 g=0000", split_mask, hgrantx);
    end
    drive(16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0000 || hmaster !== 4'd0) begin
      failures++; $display("FAIL dummy_hold got g=%h m=%0d exp g=0000 m=0", hgrantx, hmaster);
    end
    drive(16'h0, 16'h0, 16'h0001, 2'b00, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0001 || split_mask !== 16'h0) begin
      failures++; $display("FAIL default_unmask got g=%h mask=%h exp g=0001 mask=0000", hgrantx, split_mask);
    end
  endtask

  task automatic lock_with_mask();
    do_reset();
    drive(16'h0010, 16'h0, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    drive(16'h0010, 16'h0, 16'h0, 2'b11, 1'b1, 2'b00);
    step();
    drive(16'h0008, 16'h0008, 16'h0, 2'b00, 1'b1, 2'b11);
    step();
    drive(16'h0008, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    step();
  endtask

  task automatic test_lock_split_err();
    lock_with_mask();
    checks++;
    if (split_mask !== 16'h0010 || hgrantx !== 16'h0008 || hmastlock !== 1'b1) begin
      failures++; $display("FAIL lockmask_setup got mask=%h g=%h l=%b exp 0010 0008 1", split_mask, hgrantx, hmastlock);
    end
    drive(16'h0008, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b11);
    step();
    checks++;
    if (lock_split_err !== 1'b1 || hgrantx !== 16'h0001 || split_mask !== 16'h0018) begin
      failures++; $display("FAIL lock_split got err=%b g=%h mask=%h exp 1 0001 0018", lock_split_err, hgrantx, split_mask);
    end
    drive(16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 2'b00);
    step();
    checks++;
    if (lock_split_err !== 1'b0) begin failures++; $display("FAIL lock_split_pulse got=%b exp=0", lock_split_err); end
  endtask

  task automatic test_reset_mid_lock();
    lock_with_mask();
    hrst_n = 1'b0;
    step();
    checks++;
    if (hgrantx !== 16'h0001 || hmaster !== 4'd0 || hmastlock !== 1'b0 || split_mask !== 16'h0) begin
      failures++; $display("FAIL reset_mid_lock got g=%h m=%0d l=%b mask=%h exp 0001 0 0 0000",
                           hgrantx, hmaster, hmastlock, split_mask);
    end
    hrst_n = 1'b1;
    drive(16'h0008, 16'h0008, 16'h0, 2'b10, 1'b1, 2'b00);
    step();
    checks++;
    if (hgrantx !== 16'h0008 || hmastlock !== 1'b0) begin
      failures++; $display("FAIL reset_state_idle got g=%h l=%b exp g=0008 l=0", hgrantx, hmastlock);
    end
  endtask

  initial begin
    hrst_n = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 2'b00);
    step();
    test_reset();
    test_round_robin();
    test_burst();
    test_lock();
    test_split();
    test_default();
    test_lock_split_err();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
